// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scan controller.
// Holds the FSM state enum, matrix geometry and the column decoder.
package keypad_pkg;

   localparam int NUM_ROWS = 4;
   localparam int NUM_COLS = 4;
   localparam int KEY_W    = 4;

   typedef enum logic [2:0] {
      DRIVE,
      SAMPLE,
      DEB_PRESS,
      HELD,
      DEB_REL
   } state_e;

   typedef struct packed {
      logic       one;
      logic [1:0] idx;
   } col_hit_t;

   // Flags a pattern with exactly one low column and encodes its index.
   function automatic col_hit_t col_decode(input logic [NUM_COLS-1:0] c);
      col_hit_t h;
      h.one = 1'b1;
      h.idx = 2'd0;
      case (c)
         4'b1110: h.idx = 2'd0;
         4'b1101: h.idx = 2'd1;
         4'b1011: h.idx = 2'd2;
         4'b0111: h.idx = 2'd3;
         default: h.one = 1'b0;
      endcase
      return h;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer, resets to all ones (idle level of active-low pins).
// Ports: clk, rst_n (async, active-low), d_i (async input), q_o (synced).
module sync_2ff #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '1;
         sync_q <= '1;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: row drive, column sampling, press/release debounce.
// Ports: clk, reset (async low), cols (raw, active-low), rows (active-low
// drive), key_valid (accept pulse), key_code {row,col}, key_held.
module keypad_scan_ctrl
   import keypad_pkg::*;
#(
   parameter int SETTLE_CYCLES   = 4,
   parameter int DEBOUNCE_CYCLES = 60000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_COLS-1:0] cols,
   output logic [NUM_ROWS-1:0] rows,
   output logic                key_valid,
   output logic [KEY_W-1:0]    key_code,
   output logic                key_held
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   // The SAMPLE cycle (or the HELD cycle that saw the release) is the
   // first stable sample, so the counter stops one short of the total.
   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
   logic [1:0]          row_q, row_d;
   logic [1:0]          col_q, col_d;
   logic [NUM_COLS-1:0] pat_q, pat_d;
   logic [KEY_W-1:0]    code_q, code_d;
   logic                valid_q, valid_d;
   logic [NUM_COLS-1:0] cols_s;
   col_hit_t            hit;

   sync_2ff #(
      .W(NUM_COLS)
   ) u_sync (
      .clk  (clk),
      .rst_n(reset),
      .d_i  (cols),
      .q_o  (cols_s)
   );

   assign hit     = col_decode(cols_s);
   assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      row_d   = row_q;
      col_d   = col_q;
      pat_d   = pat_q;
      code_d  = code_q;
      valid_d = 1'b0;
      unique case (state_q)
         DRIVE: begin
            if (cnt_q == SETTLE_LAST) begin
               cnt_d   = '0;
               state_d = SAMPLE;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         SAMPLE: begin
            cnt_d = '0;
            if (hit.one) begin
               col_d   = hit.idx;
               pat_d   = cols_s;
               state_d = DEB_PRESS;
            end else begin
               row_d   = row_q + 2'd1;
               state_d = DRIVE;
            end
         end
         DEB_PRESS: begin
            if (cols_s != pat_q) begin
               cnt_d   = '0;
               state_d = DRIVE;
            end else if (cnt_q == DEB_LAST) begin
               cnt_d   = '0;
               state_d = HELD;
               valid_d = 1'b1;
               code_d  = {row_q, col_q};
            end else begin
               cnt_d = cnt_inc;
            end
         end
         HELD: begin
            if (cols_s == '1) begin
               cnt_d   = '0;
               state_d = DEB_REL;
            end
         end
         DEB_REL: begin
            if (cols_s != '1) begin
               cnt_d   = '0;
               state_d = HELD;
            end else if (cnt_q == DEB_LAST) begin
               cnt_d   = '0;
               row_d   = row_q + 2'd1;
               state_d = DRIVE;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = DRIVE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= DRIVE;
         cnt_q   <= '0;
         row_q   <= 2'd0;
         col_q   <= 2'd0;
         pat_q   <= '1;
         code_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         row_q   <= row_d;
         col_q   <= col_d;
         pat_q   <= pat_d;
         code_q  <= code_d;
         valid_q <= valid_d;
      end
   end

   always_comb begin
      rows        = '1;
      rows[row_q] = 1'b0;
   end

   assign key_valid = valid_q;
   assign key_code  = code_q;
   assign key_held  = (state_q == HELD) || (state_q == DEB_REL);

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl with a shorting keypad model and a
// scoreboard of expected key codes consumed on each key_valid pulse.
module tb_keypad_scan_ctrl;

   localparam int SETTLE = 3;
   localparam int DEB    = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  cols;
   logic [3:0]  rows;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        key_held;
   logic [15:0] keys = '0;

   int          n_tests = 0;
   int          n_fail = 0;
   int          pulses = 0;
   int          cyc = 0;
   logic [3:0]  sb[$];
   logic [3:0]  exp_code;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   keypad_scan_ctrl #(
      .SETTLE_CYCLES  (SETTLE),
      .DEBOUNCE_CYCLES(DEB)
   ) dut (
      .clk      (clk),
      .reset    (rst_n),
      .cols     (cols),
      .rows     (rows),
      .key_valid(key_valid),
      .key_code (key_code),
      .key_held (key_held)
   );

   // A pressed key shorts its row to its column.
   always_comb begin
      cols = '1;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (!rows[r] && keys[r*4+c]) cols[c] = 1'b0;
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && key_valid) begin
         pulses++;
         if (sb.size() == 0) begin
            check("spurious_pulse", {31'd0, key_valid}, 32'd0);
         end else begin
            exp_code = sb.pop_front();
            check("key_code_sb", {28'd0, key_code}, {28'd0, exp_code});
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic wait_rows(input logic [3:0] exp, input int max,
                            input string tag);
      int n = 0;
      while (rows !== exp && n < max) begin
         tick();
         n++;
      end
      check(tag, {28'd0, rows}, {28'd0, exp});
   endtask

   task automatic wait_pulse(input int max, input string tag);
      int p0 = pulses;
      int n = 0;
      while (pulses == p0 && n < max) begin
         tick();
         n++;
      end
      check(tag, pulses - p0, 1);
   endtask

   task automatic wait_release(input int max, input string tag);
      int n = 0;
      while (key_held !== 1'b0 && n < max) begin
         tick();
         n++;
      end
      check(tag, {31'd0, key_held}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0] er;
      int         c0;
      int         p0;

      // 1: reset values and idle scan
      rst_n = 1'b0;
      keys  = '0;
      tick(3);
      check("t1_rst_rows", {28'd0, rows}, 32'hE);
      check("t1_rst_valid", {31'd0, key_valid}, 32'd0);
      check("t1_rst_code", {28'd0, key_code}, 32'd0);
      check("t1_rst_held", {31'd0, key_held}, 32'd0);
      rst_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         er = ~(4'b0001 << ((k / 4) % 4));
         check("t1_scan_rows", {28'd0, rows}, {28'd0, er});
         tick();
      end
      check("t1_no_pulse", pulses, 0);

      // 2: clean press row 2 col 1, from a known scan position
      rst_n = 1'b0;
      keys  = 16'h0200;
      sb.push_back(4'b1001);
      tick(2);
      rst_n = 1'b1;
      c0 = cyc;
      p0 = pulses;
      wait_rows(4'b1011, 12, "t2_row2");
      check("t2_row2_lat", cyc - c0, 8);
      wait_pulse(20, "t2_pulse");
      check("t2_pulse_lat", cyc - c0, SETTLE * 2 + SETTLE + 2 + DEB);
      check("t2_code", {28'd0, key_code}, 32'h9);
      tick(10);
      check("t2_held", {31'd0, key_held}, 32'd1);
      check("t2_rows_hold", {28'd0, rows}, 32'hB);
      check("t2_one_pulse", pulses - p0, 1);

      // 4: bouncy release, then a clean one
      p0 = pulses;
      keys[9] = 1'b0; tick(5);
      check("t4_glitch_a", {31'd0, key_held}, 32'd1);
      keys[9] = 1'b1; tick(3);
      check("t4_glitch_b", {31'd0, key_held}, 32'd1);
      keys[9] = 1'b0; tick(6);
      check("t4_glitch_c", {31'd0, key_held}, 32'd1);
      keys[9] = 1'b1; tick(3);
      check("t4_glitch_d", {31'd0, key_held}, 32'd1);
      keys[9] = 1'b0;
      c0 = cyc;
      wait_release(20, "t4_release");
      check("t4_rel_lat", cyc - c0, 2 + DEB);
      check("t4_rows_next", {28'd0, rows}, 32'h7);
      check("t4_no_pulse", pulses - p0, 0);

      // 3: bouncy press row 0 col 3
      p0 = pulses;
      for (int i = 0; i < 10; i++) begin
         keys[3] = ~keys[3];
         tick(3);
      end
      check("t3_bounce_quiet", pulses - p0, 0);
      keys[3] = 1'b1;
      sb.push_back(4'b0011);
      wait_pulse(60, "t3_pulse");
      check("t3_code", {28'd0, key_code}, 32'h3);
      keys[3] = 1'b0;
      wait_release(30, "t3_release");

      // 5a: two keys in one row are rejected
      keys = 16'h0005;
      p0 = pulses;
      wait_rows(4'b1110, 20, "t5a_row0");
      wait_rows(4'b1101, 6, "t5a_advance");
      tick(32);
      check("t5a_no_pulse", pulses - p0, 0);
      keys = '0;

      // 5b: second key in the held row is ignored
      keys[7] = 1'b1;
      sb.push_back(4'b0111);
      wait_pulse(60, "t5b_pulse");
      keys[4] = 1'b1;
      p0 = pulses;
      tick(30);
      check("t5b_no_second", pulses - p0, 0);
      check("t5b_code", {28'd0, key_code}, 32'h7);
      check("t5b_held", {31'd0, key_held}, 32'd1);
      check("t5b_rows", {28'd0, rows}, 32'hD);
      // Row 2 col 0 goes down now so the next row scan debounces it.
      keys = 16'h0100;
      wait_release(30, "t5b_release");

      // 6: reset while debouncing the press
      p0 = pulses;
      tick(6);
      check("t6_pre_rows", {28'd0, rows}, 32'hB);
      check("t6_pre_held", {31'd0, key_held}, 32'd0);
      rst_n = 1'b0;
      #1;
      check("t6_rst_rows", {28'd0, rows}, 32'hE);
      check("t6_rst_valid", {31'd0, key_valid}, 32'd0);
      check("t6_rst_code", {28'd0, key_code}, 32'd0);
      check("t6_rst_held", {31'd0, key_held}, 32'd0);
      tick(3);
      check("t6_no_pulse", pulses - p0, 0);
      sb.push_back(4'b1000);
      rst_n = 1'b1;
      c0 = cyc;
      wait_pulse(30, "t6_pulse");
      check("t6_pulse_lat", cyc - c0, 19);
      check("t6_code", {28'd0, key_code}, 32'h8);
      keys = '0;
      wait_release(30, "t6_release");

      tick(5);
      check("sb_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
